// File: rtl/datain_buf_3.sv
`default_nettype none
// ============================================================================
//  Module   : datain_buf_3
//  Purpose  : Node-3 receive buffer; captures one fixed-length packet, keeps
//             an XOR checksum, flags overflow and offers a 1-cycle read port.
//  Revision : 1.0
// ============================================================================
module datain_buf_3 #(
  parameter int DATA_W  = 20,
  parameter int PKT_LEN = 30,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] datain,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rx_count,
  output logic              rx_done,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] c_PKT_LEN = (ADDR_W+1)'(PKT_LEN);
  localparam logic [ADDR_W:0] c_ONE     = (ADDR_W+1)'(1);
  localparam bit              c_SINGLE  = (PKT_LEN == 1);
  localparam int              c_DEPTH   = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;

  logic [DATA_W-1:0]   mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      csum_q  <= csum_d;
    end
  end

  // clear outranks a same-cycle flit; that flit is neither stored nor counted as overflow.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    csum_d    = csum_q;
    w_wr_en   = 1'b0;
    w_wr_addr = count_q[ADDR_W-1:0];
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
      csum_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        S_IDLE: begin
          w_wr_en   = 1'b1;
          w_wr_addr = '0;
          count_d   = c_ONE;
          csum_d    = csum_q ^ datain;
          state_d   = c_SINGLE ? S_DONE : S_RECV;
        end
        S_RECV: begin
          w_wr_en = 1'b1;
          count_d = count_q + c_ONE;
          csum_d  = csum_q ^ datain;
          if (count_d == c_PKT_LEN) state_d = S_DONE;
        end
        S_DONE: ovf_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !RST) mem[w_wr_addr] <= datain;
  end

  // Non-blocking update of mem gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= ({1'b0, rd_addr} < c_PKT_LEN) ? mem[rd_addr] : '0;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rx_count = count_q;
  assign rx_done  = done_q;
  assign overflow = ovf_q;
  assign checksum = csum_q;

endmodule
`default_nettype wire

// File: tb/tb_datain_buf_3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datain_buf_3
//  Purpose  : Self-checking bench for datain_buf_3 with a queue-based model.
//  Revision : 1.0
// ============================================================================
module tb_datain_buf_3;

  localparam int DATA_W  = 20;
  localparam int PKT_LEN = 30;
  localparam int ADDR_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] datain = '0;
  logic              clear = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   rx_count;
  logic              rx_done;
  logic              overflow;
  logic [DATA_W-1:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the packet is the ordered list of accepted flits; memory persists.
  logic [DATA_W-1:0] flits[$];
  logic [DATA_W-1:0] mem_m [32];
  bit                ovf_m = 1'b0;
  logic [DATA_W-1:0] rdd_m = '0;
  bit                rdv_m = 1'b0;

  datain_buf_3 #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .RST(rst), .in_valid(in_valid), .datain(datain), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rx_count(rx_count), .rx_done(rx_done), .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply current inputs for one edge, advance the model, then check every output.
  task automatic step();
    logic [DATA_W-1:0] csum;
    if (rst) begin
      rdv_m = 1'b0; rdd_m = '0;
    end else if (rd_en) begin
      rdv_m = 1'b1;
      rdd_m = (int'(rd_addr) < PKT_LEN) ? mem_m[rd_addr] : '0;
    end else begin
      rdv_m = 1'b0;
    end
    if (rst || clear) begin
      flits.delete();
      ovf_m = 1'b0;
    end else if (in_valid) begin
      if (flits.size() == PKT_LEN) ovf_m = 1'b1;
      else begin
        mem_m[flits.size()] = datain;
        flits.push_back(datain);
      end
    end
    @(posedge clk);
    #1;
    csum = '0;
    foreach (flits[i]) csum ^= flits[i];
    chk("rx_count", 32'(rx_count), 32'(flits.size()));
    chk("rx_done",  32'(rx_done),  32'(flits.size() == PKT_LEN));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("checksum", 32'(checksum), 32'(csum));
    chk("rd_valid", 32'(rd_valid), 32'(rdv_m));
    chk("rd_data",  32'(rd_data),  32'(rdd_m));
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1; datain = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_count", 32'(rx_count), 0);
    chk("rst_done",  32'(rx_done), 0);
    chk("rst_rdv",   32'(rd_valid), 0);

    // 1: back-to-back packet 1..30
    for (int k = 1; k <= PKT_LEN; k++) begin
      send(DATA_W'(k));
      if (k == PKT_LEN - 1) chk("t1_done_early", 32'(rx_done), 0);
    end
    chk("t1_done",  32'(rx_done), 1);
    chk("t1_count", 32'(rx_count), 30);
    chk("t1_csum",  32'(checksum), 32'h1F);
    chk("t1_ovf",   32'(overflow), 0);

    // 2: same packet with 1-3 idle gaps, then readback
    clear = 1'b1; step(); clear = 1'b0;
    for (int k = 1; k <= PKT_LEN; k++) begin
      send(DATA_W'(k));
      idle($urandom_range(1, 3));
    end
    chk("t2_done",  32'(rx_done), 1);
    chk("t2_count", 32'(rx_count), 30);
    chk("t2_csum",  32'(checksum), 32'h1F);
    for (int k = 0; k < PKT_LEN; k++) begin
      rd(ADDR_W'(k));
      chk("t2_rdata", 32'(rd_data), 32'(k + 1));
    end
    step();
    chk("t2_rd_hold_v", 32'(rd_valid), 0);
    chk("t2_rd_hold_d", 32'(rd_data), 30);

    // 3: overflow in DONE
    send(20'hABCDE);
    chk("t3_ovf",   32'(overflow), 1);
    chk("t3_count", 32'(rx_count), 30);
    chk("t3_csum",  32'(checksum), 32'h1F);
    rd(0);
    chk("t3_mem0",  32'(rd_data), 1);

    // 4: clear with simultaneous flit
    clear = 1'b1; in_valid = 1'b1; datain = 20'h12345;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("t4_count", 32'(rx_count), 0);
    chk("t4_ovf",   32'(overflow), 0);
    chk("t4_done",  32'(rx_done), 0);
    send(20'h00055);
    chk("t4_csum",  32'(checksum), 32'h55);
    rd(0);
    chk("t4_mem0",  32'(rd_data), 32'h55);

    // 5: reset mid-packet, then a full packet
    for (int k = 0; k < 9; k++) send(DATA_W'(32'h200 + k));
    chk("t5_count10", 32'(rx_count), 10);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_count", 32'(rx_count), 0);
    chk("t5_csum",  32'(checksum), 0);
    chk("t5_rdd",   32'(rd_data), 0);
    for (int k = 1; k <= PKT_LEN; k++) send(DATA_W'(k));
    chk("t5_done",  32'(rx_done), 1);
    chk("t5_csum2", 32'(checksum), 32'h1F);
    rd(0);
    chk("t5_mem0",  32'(rd_data), 1);

    // 6: out-of-range read and read-before-write collision
    rd(5'd31);
    chk("t6_oor_d", 32'(rd_data), 0);
    chk("t6_oor_v", 32'(rd_valid), 1);
    clear = 1'b1; step(); clear = 1'b0;
    for (int k = 0; k < 5; k++) send(DATA_W'(32'h300 + k));
    in_valid = 1'b1; datain = 20'h77777; rd_en = 1'b1; rd_addr = 5'd5;
    step();
    in_valid = 1'b0; rd_en = 1'b0;
    chk("t6_rbw",  32'(rd_data), 6);
    rd(5);
    chk("t6_new",  32'(rd_data), 32'h77777);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      clear    = ($urandom_range(0, 149) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      datain   = DATA_W'($urandom);
      rd_en    = $urandom_range(0, 1) == 1;
      rd_addr  = ADDR_W'($urandom);
      step();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
